capture_bram_arbiter: RTL
=========================

Name: capture_bram_arbiter

Overview:
- Owns the single port of the 256K x 8 capture BRAM and shares it between three requesters: the logic-capture writer (transition samples), a buffer-clear sweep engine, and the host readout path.
- Priority is fixed: capture > clear > read. Capture writes are never delayed or dropped.
- Sits between the capture block, the register/host interface and the BRAM primitive.

Parameters:
- ADDR_W, 18, BRAM address width.
- DATA_W, 8, BRAM data width.
- RD_LAT, 1, BRAM read latency in clocks (address sampled to dout valid); legal 1..3.
- LAST_ADDR, 2**ADDR_W-1, final address written by the clear sweep.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cap_we  in  1  single-cycle capture write strobe.
- cap_addr  in  ADDR_W  capture write address.
- cap_din  in  DATA_W  capture write data.
- clr_start  in  1  pulse: start zero-fill of BRAM.
- clr_busy  out  1  clear sweep in progress.
- clr_done  out  1  one-cycle pulse when sweep completes.
- rd_req  in  1  host read request; held with rd_addr stable until rd_ack.
- rd_addr  in  ADDR_W  host read address.
- rd_ack  out  1  one-cycle pulse: read issued to BRAM.
- rd_valid  out  1  one-cycle pulse: rd_data valid.
- rd_data  out  DATA_W  read data, held until next rd_valid.
- bram_en  out  1  BRAM enable.
- bram_we  out  1  BRAM write enable.
- bram_addr  out  ADDR_W  BRAM address.
- bram_din  out  DATA_W  BRAM write data.
- bram_dout  in  DATA_W  BRAM read data.

Behaviour:
- Reset values: all outputs 0. Clear FSM is C_IDLE, read FSM is R_IDLE, clear pointer is 0, and any pending or in-flight read is discarded (no rd_valid after reset).
- All BRAM outputs are registered. A request sampled at edge N appears on the bram_* outputs after edge N.
- Per-edge arbitration:
  - cap_we=1: issue write of cap_din to cap_addr.
  - Else if C_RUN: issue write of 0 to clr_ptr, then clr_ptr+1.
  - Else if R_IDLE and rd_req: issue read of rd_addr, rd_ack=1, enter R_WAIT.
  - Else: idle cycle with bram_en=0 and bram_we=0; bram_addr and bram_din hold their last values.
- Clear FSM:
  - C_IDLE -> C_RUN on clr_start. clr_busy=1 from the next cycle; clr_ptr=0.
  - In C_RUN, clr_ptr advances only in cycles where the clear wins arbitration.
  - After the write of LAST_ADDR is issued: -> C_IDLE, clr_busy=0, clr_done pulses in the same registered cycle as that final write.
  - clr_start while C_RUN is ignored.
- Read FSM:
  - R_IDLE -> R_WAIT on grant. A wait counter counts RD_LAT+1 edges.
  - rd_valid pulses, with rd_data = bram_dout registered, exactly RD_LAT+1 cycles after the rd_ack cycle.
  - Then -> R_IDLE; a new grant is possible on that same edge.
  - No read is granted while C_RUN; rd_req waits until the clear finishes.
  - At most one read is outstanding. Because rd_ack is registered, the requester still drives rd_req on the grant edge; R_WAIT prevents a double grant.
- Capture preemption: a capture write during R_WAIT does not disturb the in-flight read. The read was already issued, so its data is captured regardless of later writes.
- Simultaneous events:
  - cap_we with clr_start: the capture write issues and the clear starts its first write on the following eligible cycle.
  - cap_we with rd_req: the read stays pending with no rd_ack.
  - Same-address capture write and pending read: the read is issued later and returns the new data.
- Reset asserted mid-sweep or mid-read: immediate return to idle. Reset does not resume a sweep.

Decomposition:
- Shared package capture_pkg holds:
  - ADDR_W and DATA_W defaults;
  - clear FSM state enum {C_IDLE, C_RUN};
  - read FSM state enum {R_IDLE, R_WAIT};
  - grant-select encoding {G_NONE, G_CAP, G_CLR, G_RD}.
- One natural sub-module, capture_clear_engine: clear FSM, clr_ptr, clr_busy/clr_done. It takes a "granted" input and produces a write request.
- Arbitration, read FSM and output registers live in the top.

Test Plan:
- Read only, RD_LAT=1: preload addr 0x00010=0xA5; rd_req addr 0x00010 -> rd_ack one cycle later, rd_valid exactly 2 cycles after rd_ack, rd_data=0xA5, exactly one bram read cycle.
- Capture priority: cap_we every cycle for 10 cycles with rd_req held -> 10 consecutive bram writes with cap data, rd_ack only in the cycle after cap_we drops, correct data returned.
- Clear sweep with LAST_ADDR=15: clr_start -> 16 consecutive zero writes, addr 0..15, clr_done pulses with the addr-15 write, clr_busy low next cycle, rd_req during the sweep acked only afterward.
- Clear preemption: cap_we pulses while clr_ptr=5 -> bram write at cap_addr, the next clear write is still addr 5, no address skipped, total clear writes=16.
- Read/write hazard: rd_req addr 0x20 in the same cycle as cap_we addr 0x20 data 0x3C -> read issued next cycle, rd_data=0x3C.
- Reset mid-operation: assert reset during R_WAIT and again at clr_ptr=7 -> all outputs 0, no rd_valid or clr_done afterward, a new clr_start restarts at addr 0.

Source files
------------

// File: rtl/capture_pkg.sv
// Shared types for the capture BRAM arbiter: default widths, FSM state
// encodings and the per-cycle grant selector.
package capture_pkg;

  localparam int CAP_ADDR_W = 18;
  localparam int CAP_DATA_W = 8;

  typedef enum logic {C_IDLE, C_RUN} clr_state_t;
  typedef enum logic {R_IDLE, R_WAIT} rd_state_t;
  typedef enum logic [1:0] {G_NONE, G_CAP, G_CLR, G_RD} grant_t;

endpackage

// File: rtl/capture_clear_engine.sv
// Zero-fill sweep engine: walks the clear pointer from 0 to LAST_ADDR,
// advancing only on cycles where the arbiter grants its write request.
module capture_clear_engine
  import capture_pkg::*;
#(
  parameter int          ADDR_W    = CAP_ADDR_W,
  parameter int unsigned LAST_ADDR = 2**ADDR_W-1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic              i_granted,
  output logic              o_req,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_busy,
  output logic              o_done
);

  localparam logic [ADDR_W-1:0] L_LAST = ADDR_W'(LAST_ADDR);

  clr_state_t        r_state;
  clr_state_t        w_next;
  logic [ADDR_W-1:0] r_ptr;
  logic              r_done;
  logic              w_last;

  assign w_last = (r_ptr == L_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= C_IDLE;
    else       r_state <= w_next;
  end

  // A start pulse during a sweep is ignored: only C_IDLE looks at i_start.
  always_comb begin
    w_next = r_state;
    case (r_state)
      C_IDLE: if (i_start) w_next = C_RUN;
      C_RUN:  if (i_granted && w_last) w_next = C_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == C_RUN) && i_granted && w_last;
      if (r_state == C_IDLE && i_start)
        r_ptr <= '0;
      else if (r_state == C_RUN && i_granted)
        r_ptr <= r_ptr + ADDR_W'(1);
    end
  end

  always_comb begin
    o_req  = (r_state == C_RUN);
    o_busy = (r_state == C_RUN);
    o_addr = r_ptr;
    o_done = r_done;
  end

endmodule

// File: rtl/capture_bram_arbiter.sv
// Single-port capture BRAM arbiter: capture > clear > read, fixed priority,
// with all BRAM-facing signals registered and one outstanding host read.
module capture_bram_arbiter
  import capture_pkg::*;
#(
  parameter int          ADDR_W    = CAP_ADDR_W,
  parameter int          DATA_W    = CAP_DATA_W,
  parameter int          RD_LAT    = 1,
  parameter int unsigned LAST_ADDR = 2**ADDR_W-1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cap_we,
  input  logic [ADDR_W-1:0] cap_addr,
  input  logic [DATA_W-1:0] cap_din,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  input  logic [DATA_W-1:0] bram_dout
);

  grant_t            w_grant;
  logic              w_clr_req;
  logic [ADDR_W-1:0] w_clr_addr;
  rd_state_t         r_rd_state;
  rd_state_t         w_rd_next;
  logic [1:0]        r_wait_cnt;
  logic              w_rd_done;
  logic              w_rd_free;

  capture_clear_engine #(
    .ADDR_W    (ADDR_W),
    .LAST_ADDR (LAST_ADDR)
  ) u_clear (
    .clk       (clk),
    .reset     (reset),
    .i_start   (clr_start),
    .i_granted (w_grant == G_CLR),
    .o_req     (w_clr_req),
    .o_addr    (w_clr_addr),
    .o_busy    (clr_busy),
    .o_done    (clr_done)
  );

  always_comb begin
    w_grant = G_NONE;
    if (cap_we)                    w_grant = G_CAP;
    else if (w_clr_req)            w_grant = G_CLR;
    else if (rd_req && w_rd_free)  w_grant = G_RD;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_rd_state <= R_IDLE;
    else       r_rd_state <= w_rd_next;
  end

  // The edge that retires a read may also grant the next one.
  always_comb begin
    w_rd_next = r_rd_state;
    case (r_rd_state)
      R_IDLE: if (w_grant == G_RD) w_rd_next = R_WAIT;
      R_WAIT: if (w_rd_done) w_rd_next = (w_grant == G_RD) ? R_WAIT : R_IDLE;
    endcase
  end

  always_comb begin
    w_rd_done = (r_rd_state == R_WAIT) && (r_wait_cnt == 2'(RD_LAT));
    w_rd_free = (r_rd_state == R_IDLE) || w_rd_done;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wait_cnt <= '0;
      rd_ack     <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
    end else begin
      rd_ack   <= (w_grant == G_RD);
      rd_valid <= w_rd_done;
      if (w_rd_done) rd_data <= bram_dout;
      if (w_grant == G_RD)            r_wait_cnt <= '0;
      else if (r_rd_state == R_WAIT)  r_wait_cnt <= r_wait_cnt + 2'd1;
    end
  end

  // Idle cycles drop en/we but leave address and data where they were.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bram_en   <= 1'b0;
      bram_we   <= 1'b0;
      bram_addr <= '0;
      bram_din  <= '0;
    end else begin
      case (w_grant)
        G_CAP: begin
          bram_en   <= 1'b1;
          bram_we   <= 1'b1;
          bram_addr <= cap_addr;
          bram_din  <= cap_din;
        end
        G_CLR: begin
          bram_en   <= 1'b1;
          bram_we   <= 1'b1;
          bram_addr <= w_clr_addr;
          bram_din  <= '0;
        end
        G_RD: begin
          bram_en   <= 1'b1;
          bram_we   <= 1'b0;
          bram_addr <= rd_addr;
        end
        default: begin
          bram_en <= 1'b0;
          bram_we <= 1'b0;
        end
      endcase
    end
  end

endmodule
